// File: rtl/reverb_template_m2s_fifo_ffta.sv
// Memory-mapped-to-stream FIFO: CPU words written over Avalon-MM leave in order
// on a registered show-ahead Avalon-ST source. Address 1 reads back the fill level.
module reverb_template_m2s_fifo_ffta #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int ADDR_W     = 6
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  avalonmm_write_slave_address,
  input  logic                  avalonmm_write_slave_write,
  input  logic [DATA_WIDTH-1:0] avalonmm_write_slave_writedata,
  input  logic                  avalonmm_write_slave_read,
  output logic [31:0]           avalonmm_write_slave_readdata,
  output logic                  avalonmm_write_slave_waitrequest,
  output logic [DATA_WIDTH-1:0] avalonst_source_data,
  output logic                  avalonst_source_valid,
  input  logic                  avalonst_source_ready
);

  localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0]     r_wr_ptr;
  logic [ADDR_W-1:0]     r_rd_ptr;
  logic [ADDR_W:0]       r_level;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;

  logic                  w_full;
  logic                  w_accept;
  logic                  w_xfer;
  logic                  w_load;
  logic [ADDR_W:0]       w_ram_cnt;

  // The level includes the word parked in the output register; the rest sit in RAM.
  assign w_full    = (r_level == LVL_FULL);
  assign w_ram_cnt = r_level - {{ADDR_W{1'b0}}, r_valid};
  assign w_accept  = avalonmm_write_slave_write & ~avalonmm_write_slave_address & ~w_full;
  assign w_xfer    = r_valid & avalonst_source_ready;
  assign w_load    = (w_ram_cnt != '0) & (~r_valid | w_xfer);

  assign avalonmm_write_slave_waitrequest = ~reset_n |
    (avalonmm_write_slave_write & ~avalonmm_write_slave_address & w_full);
  assign avalonmm_write_slave_readdata =
    (avalonmm_write_slave_read & avalonmm_write_slave_address) ? 32'(r_level) : 32'd0;

  assign avalonst_source_valid = r_valid;
  assign avalonst_source_data  = r_data;

  // Storage RAM carries no reset so it can map onto block memory.
  always_ff @(posedge clock) begin
    if (w_accept)
      r_mem[r_wr_ptr] <= avalonmm_write_slave_writedata;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_valid  <= 1'b0;
      r_data   <= '0;
    end else begin
      if (w_accept)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_load) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_data   <= r_mem[r_rd_ptr];
        r_valid  <= 1'b1;
      end else if (w_xfer) begin
        r_valid  <= 1'b0;
      end
      case ({w_accept, w_xfer})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: tb/tb_reverb_template_m2s_fifo_ffta.sv
// Directed bench for the m2s FIFO: reset, single word, full/stall, throughput,
// backpressure, status port and mid-operation reset.
module tb_reverb_template_m2s_fifo_ffta;

  logic        clock;
  logic        reset_n;
  logic        address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [31:0] st_data;
  logic        st_valid;
  logic        st_ready;

  int n_assert = 0;
  int n_fail   = 0;

  reverb_template_m2s_fifo_ffta #(.DATA_WIDTH(32), .DEPTH(64), .ADDR_W(6)) dut (
    .clock                            (clock),
    .reset_n                          (reset_n),
    .avalonmm_write_slave_address     (address),
    .avalonmm_write_slave_write       (write),
    .avalonmm_write_slave_writedata   (writedata),
    .avalonmm_write_slave_read        (read),
    .avalonmm_write_slave_readdata    (readdata),
    .avalonmm_write_slave_waitrequest (waitrequest),
    .avalonst_source_data             (st_data),
    .avalonst_source_valid            (st_valid),
    .avalonst_source_ready            (st_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Combinational status peek inside the current cycle; bus state restored before the edge.
  task automatic peek_level(output logic [31:0] lv);
    logic sa, sw, sr;
    sa = address; sw = write; sr = read;
    address = 1'b1; write = 1'b0; read = 1'b1;
    #1;
    lv = readdata;
    address = sa; write = sw; read = sr;
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0; write = 1'b0; read = 1'b0; address = 1'b0;
    writedata = '0; st_ready = 1'b0;
    tick; tick;
    reset_n = 1'b1;
    tick;
  endtask

  task automatic push_words(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      address = 1'b0; write = 1'b1; writedata = base + 32'(i);
      tick;
    end
    write = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] lv;
    reset_n = 1'b0; write = 1'b1; address = 1'b0; read = 1'b0;
    writedata = 32'h1234; st_ready = 1'b0;
    #3;
    n_assert++;
    if (waitrequest !== 1'b1) begin n_fail++; $display("FAIL reset_waitreq: got %b want 1", waitrequest); end
    n_assert++;
    if (st_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", st_valid); end
    n_assert++;
    if (st_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", st_data); end
    write = 1'b0;
    peek_level(lv);
    n_assert++;
    if (lv !== 32'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", lv); end
    tick;
    reset_n = 1'b1;
    tick;
  endtask

  task automatic test_single;
    logic [31:0] lv;
    do_reset;
    st_ready = 1'b1;
    address = 1'b0; write = 1'b1; writedata = 32'hA5A5_0001;
    tick;
    write = 1'b0;
    peek_level(lv);
    n_assert++;
    if (lv !== 32'd1) begin n_fail++; $display("FAIL single_level1: got %0d want 1", lv); end
    n_assert++;
    if (st_valid !== 1'b0) begin n_fail++; $display("FAIL single_nobypass: got valid %b want 0", st_valid); end
    tick;
    n_assert++;
    if (st_valid !== 1'b1 || st_data !== 32'hA5A5_0001) begin
      n_fail++; $display("FAIL single_out: got %b/%h want 1/a5a50001", st_valid, st_data);
    end
    tick;
    n_assert++;
    if (st_valid !== 1'b0) begin n_fail++; $display("FAIL single_popped: got valid %b want 0", st_valid); end
    peek_level(lv);
    n_assert++;
    if (lv !== 32'd0) begin n_fail++; $display("FAIL single_level0: got %0d want 0", lv); end
  endtask

  task automatic test_full;
    logic [31:0] lv;
    int exp;
    do_reset;
    st_ready = 1'b0;
    push_words(64, 32'd0);
    peek_level(lv);
    n_assert++;
    if (lv !== 32'd64) begin n_fail++; $display("FAIL full_level: got %0d want 64", lv); end
    n_assert++;
    if (st_valid !== 1'b1 || st_data !== 32'd0) begin
      n_fail++; $display("FAIL full_head: got %b/%h want 1/0", st_valid, st_data);
    end
    address = 1'b0; write = 1'b1; writedata = 32'd64;
    #1;
    n_assert++;
    if (waitrequest !== 1'b1) begin n_fail++; $display("FAIL full_stall: got %b want 1", waitrequest); end
    st_ready = 1'b1;
    #1;
    n_assert++;
    if (waitrequest !== 1'b1) begin n_fail++; $display("FAIL full_stall_pop: got %b want 1", waitrequest); end
    tick;
    st_ready = 1'b0;
    n_assert++;
    if (waitrequest !== 1'b0) begin n_fail++; $display("FAIL full_release: got %b want 0", waitrequest); end
    n_assert++;
    if (st_data !== 32'd1) begin n_fail++; $display("FAIL full_next: got %h want 1", st_data); end
    tick;
    write = 1'b0;
    peek_level(lv);
    n_assert++;
    if (lv !== 32'd64) begin n_fail++; $display("FAIL full_refill: got %0d want 64", lv); end
    st_ready = 1'b1;
    exp = 1;
    for (int c = 0; c < 80 && exp <= 64; c++) begin
      if (st_valid) begin
        n_assert++;
        if (st_data !== 32'(exp)) begin n_fail++; $display("FAIL full_order: got %0d want %0d", st_data, exp); end
        exp++;
      end
      tick;
    end
    n_assert++;
    if (exp !== 65 || st_valid !== 1'b0) begin
      n_fail++; $display("FAIL full_drain: got next %0d valid %b want 65/0", exp, st_valid);
    end
    st_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] lv;
    int rx;
    do_reset;
    st_ready = 1'b1;
    rx = 0;
    for (int i = 0; i < 200; i++) begin
      address = 1'b0; write = 1'b1; writedata = 32'h1000 + 32'(i);
      tick;
      if (st_valid) begin
        n_assert++;
        if (st_data !== 32'h1000 + 32'(rx)) begin
          n_fail++; $display("FAIL b2b_order: got %h want %h", st_data, 32'h1000 + 32'(rx));
        end
        rx++;
      end
      peek_level(lv);
      n_assert++;
      if (lv > 32'd2) begin n_fail++; $display("FAIL b2b_level: got %0d want <=2", lv); end
    end
    write = 1'b0;
    n_assert++;
    if (rx !== 199) begin n_fail++; $display("FAIL b2b_rate: got %0d beats want 199", rx); end
    for (int c = 0; c < 10 && rx < 200; c++) begin
      tick;
      if (st_valid) begin
        n_assert++;
        if (st_data !== 32'h1000 + 32'(rx)) begin
          n_fail++; $display("FAIL b2b_tail: got %h want %h", st_data, 32'h1000 + 32'(rx));
        end
        rx++;
      end
    end
    tick;
    n_assert++;
    if (rx !== 200 || st_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_count: got %0d valid %b want 200/0", rx, st_valid);
    end
    st_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    int          wi, rx;
    logic        hold;
    logic [31:0] pd;
    do_reset;
    wi = 0; rx = 0; hold = 1'b0; pd = '0;
    for (int c = 0; c < 60 && rx < 10; c++) begin
      if (hold) begin
        n_assert++;
        if (st_valid !== 1'b1 || st_data !== pd) begin
          n_fail++; $display("FAIL bp_hold: got %b/%h want 1/%h", st_valid, st_data, pd);
        end
      end
      st_ready = (c % 2 == 0);
      if (st_valid && st_ready) begin
        n_assert++;
        if (st_data !== 32'h2000 + 32'(rx)) begin
          n_fail++; $display("FAIL bp_order: got %h want %h", st_data, 32'h2000 + 32'(rx));
        end
        rx++;
      end
      hold = st_valid & ~st_ready;
      pd = st_data;
      address = 1'b0;
      write = (wi < 10);
      writedata = 32'h2000 + 32'(wi);
      if (wi < 10) wi++;
      tick;
    end
    write = 1'b0;
    st_ready = 1'b0;
    n_assert++;
    if (rx !== 10 || st_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_count: got %0d valid %b want 10/0", rx, st_valid);
    end
  endtask

  task automatic test_status;
    logic [31:0] lv;
    do_reset;
    st_ready = 1'b0;
    push_words(37, 32'h3000);
    address = 1'b1; read = 1'b1;
    #1;
    n_assert++;
    if (readdata !== 32'h0000_0025) begin n_fail++; $display("FAIL status_read: got %h want 00000025", readdata); end
    n_assert++;
    if (waitrequest !== 1'b0) begin n_fail++; $display("FAIL status_wait: got %b want 0", waitrequest); end
    read = 1'b0; write = 1'b1; writedata = 32'hDEAD_BEEF;
    #1;
    n_assert++;
    if (waitrequest !== 1'b0) begin n_fail++; $display("FAIL status_wr_wait: got %b want 0", waitrequest); end
    tick;
    write = 1'b0; address = 1'b0;
    peek_level(lv);
    n_assert++;
    if (lv !== 32'd37) begin n_fail++; $display("FAIL status_wr_ignored: got %0d want 37", lv); end
    read = 1'b1;
    #1;
    n_assert++;
    if (readdata !== 32'd0) begin n_fail++; $display("FAIL status_addr0: got %h want 0", readdata); end
    read = 1'b0;
    tick;
    peek_level(lv);
    n_assert++;
    if (lv !== 32'd37) begin n_fail++; $display("FAIL status_noside: got %0d want 37", lv); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] lv;
    do_reset;
    st_ready = 1'b0;
    push_words(20, 32'h4000);
    tick;
    n_assert++;
    if (st_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: got valid %b want 1", st_valid); end
    #2;
    reset_n = 1'b0;
    #1;
    n_assert++;
    if (st_valid !== 1'b0 || st_data !== 32'd0) begin
      n_fail++; $display("FAIL rmid_async: got %b/%h want 0/0", st_valid, st_data);
    end
    peek_level(lv);
    n_assert++;
    if (lv !== 32'd0) begin n_fail++; $display("FAIL rmid_level: got %0d want 0", lv); end
    tick;
    reset_n = 1'b1;
    tick;
    address = 1'b0; write = 1'b1; writedata = 32'hBEEF_0001;
    tick;
    writedata = 32'hBEEF_0002;
    tick;
    write = 1'b0;
    st_ready = 1'b1;
    for (int c = 0; c < 10 && !st_valid; c++) tick;
    n_assert++;
    if (st_valid !== 1'b1 || st_data !== 32'hBEEF_0001) begin
      n_fail++; $display("FAIL rmid_first: got %b/%h want 1/beef0001", st_valid, st_data);
    end
    tick;
    n_assert++;
    if (st_valid !== 1'b1 || st_data !== 32'hBEEF_0002) begin
      n_fail++; $display("FAIL rmid_second: got %b/%h want 1/beef0002", st_valid, st_data);
    end
    tick;
    st_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; address = 1'b0; write = 1'b0; writedata = '0;
    read = 1'b0; st_ready = 1'b0;
    test_reset;
    test_single;
    test_full;
    test_back_to_back;
    test_backpressure;
    test_status;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/reverb_template_m2s_fifo_ffta.md
Name: reverb_template_m2s_fifo_ffta

Overview:
- Memory-mapped-to-stream FIFO: the transmit-side counterpart of the s2m FIFO.
- Nios/CPU writes 32-bit words over an Avalon-MM write slave; the words are emitted in order on an Avalon-ST source feeding the FFT/reverb datapath.
- Address 1 provides a read-only fill-level status register for software flow control.
- Single clock domain; self-contained register/RAM FIFO storage (no vendor FIFO macro).

Parameters:
DATA_WIDTH, 32, width of MM writedata and ST data
DEPTH, 64, total word capacity (power of two)
ADDR_W, 6, log2(DEPTH); level width is ADDR_W+1

Ports:
clock  in  1  system clock, all logic rising-edge
reset_n  in  1  asynchronous active-low reset
avalonmm_write_slave_address  in  1  0 = data port, 1 = status port
avalonmm_write_slave_write  in  1  MM write strobe
avalonmm_write_slave_writedata  in  DATA_WIDTH  word to enqueue
avalonmm_write_slave_read  in  1  MM read strobe (status only)
avalonmm_write_slave_readdata  out  32  status readout
avalonmm_write_slave_waitrequest  out  1  stall of current MM transfer
avalonst_source_data  out  DATA_WIDTH  stream data
avalonst_source_valid  out  1  stream data valid
avalonst_source_ready  in  1  downstream ready (readyLatency 0)

Behaviour:
- Reset (async assert, sync release): level=0, rd/wr pointers=0, source_valid=0, source_data=0, readdata=0, and waitrequest=1 while reset_n=0.
- Level: count of words held, including the word in the output register; range 0..DEPTH; full = (level==DEPTH).
- MM write accept: address==0 & write & !full. The word is stored at the clock edge; the pointer wraps DEPTH-1 -> 0.
- waitrequest = write & address==0 & full, evaluated on the current level only.
  - A same-cycle stream pop does not release the stall; the write is accepted on the next cycle.
- Writes to address 1 are ignored: waitrequest=0, state unchanged.
- MM read at address 1: readdata = zero-extended level, combinational, waitrequest=0.
- MM read at address 0 returns 0; it has no side effect.
- Stream output is registered (show-ahead):
  - A word accepted at edge N into an empty FIFO gives source_valid=1 after edge N+1; there is no same-cycle bypass.
  - Transfer occurs when source_valid & source_ready.
  - On transfer, the next word (if any) loads into the output register at the same edge, so back-to-back beats continue at 1 word/cycle.
- source_data is held stable while source_valid & !source_ready.
- source_valid never drops without a transfer (except on reset).
- Simultaneous accept and transfer: level unchanged; ordering preserved.
- Level updates:
  - +1 on accept only.
  - -1 on transfer only.
  - Underflow is impossible: transfer requires valid.
  - Overflow is impossible: accept requires !full.
- Word order is strictly FIFO; the wrap-around at DEPTH must not reorder or duplicate words.
- Reset mid-operation discards all contents immediately; source_valid falls asynchronously.

Test Plan:
- Reset, then write 0xA5A5_0001 (ready=1) -> level=1 after the edge, source_valid=1 one cycle after accept with data 0xA5A5_0001, popped next edge, level returns to 0.
- ready=0; write 64 words 0..63 -> level=64, 65th write sees waitrequest=1; raise ready for 1 cycle -> 65th write accepted on the following cycle; stream outputs 0,1,2... in order.
- Continuous write and ready=1 for 200 words -> 1 word/cycle throughput, level constant at ≤2, pointers wrap 3×, output sequence exactly matches input.
- ready toggled 1010... during a 10-word burst -> source_data is stable whenever valid & !ready; no word dropped or repeated.
- Status read at address 1 with 37 words queued -> readdata=0x0000_0025, waitrequest=0; write to address 1 leaves level at 37.
- Assert reset_n low with 20 words queued -> source_valid=0 and level=0 immediately; after release, the first new write is the first word streamed.
